ahb_slave_mmio: RTL and testbench

- Parametrised AHB slave for the crypto accelerator, replacing the fixed single-status interface.
- Adds a wider key bank, full AHB address/data-phase pipelining, and wait-state insertion on receive/transmit FIFO back-pressure.
- Adds a stall timeout and two-cycle ERROR responses for illegal accesses.
- Sits between the AHB interconnect and the rcv/tx FIFOs and crypto control core.

---
 rtl/ahb_slave_pkg.sv | 38 +++
 rtl/ahb_key_bank.sv | 47 ++++
 rtl/ahb_slave_mmio.sv | 170 +++++++++++++++++
 tb/tb_ahb_slave_mmio.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_pkg.sv
// Shared encodings for the crypto accelerator AHB slave.
package ahb_slave_pkg;

    // Transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Slave responses
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Only 32-bit transfers are supported
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Register byte offsets
    localparam int unsigned OFF_DATA   = 32'h00;
    localparam int unsigned OFF_STATUS = 32'h04;
    localparam int unsigned OFF_CTRL   = 32'h08;
    localparam int unsigned OFF_KEY    = 32'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_STALL,
        ST_ERR1,
        ST_ERR2
    } state_e;

    typedef enum logic [1:0] {
        SEL_DATA,
        SEL_STATUS,
        SEL_CTRL,
        SEL_KEY
    } reg_sel_e;

endpackage

// File: rtl/ahb_key_bank.sv
// Key register bank: word writes, indexed read-back and key_load pulse.
module ahb_key_bank #(
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          idx_i,
    input  logic [31:0]               wdata_i,
    output logic [31:0]               rdata_o,
    output logic [32*KEY_WORDS-1:0]   key_o,
    output logic                      key_load_o
);

    logic [KEY_WORDS-1:0][31:0] key_q;
    logic                       key_load_q;

    // Key words update on the completing write; key_load follows the last word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q      <= '0;
            key_load_q <= 1'b0;
        end else begin
            for (int k = 0; k < KEY_WORDS; k++) begin
                if (we_i && (idx_i == IDX_W'(k))) begin
                    key_q[k] <= wdata_i;
                end
            end
            key_load_q <= we_i && (idx_i == IDX_W'(KEY_WORDS - 1));
        end
    end

    // Read mux over the bank
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < KEY_WORDS; k++) begin
            if (idx_i == IDX_W'(k)) begin
                rdata_o = key_q[k];
            end
        end
    end

    assign key_o      = key_q;
    assign key_load_o = key_load_q;

endmodule

// File: rtl/ahb_slave_mmio.sv
// AHB slave fronting the crypto core: FIFO data port, status, control and key bank.
module ahb_slave_mmio
    import ahb_slave_pkg::*;
#(
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned STATUS_W  = 5,
    parameter int unsigned STALL_MAX = 16,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [ADDR_W-1:0]        HADDR,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HSIZE,
    input  logic                     HWRITE,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic                     HREADYOUT,
    output logic [1:0]               HRESP,
    output logic [31:0]              HRDATA,
    input  logic [STATUS_W-1:0]      status,
    input  logic                     rcv_full,
    output logic                     rcv_enq,
    output logic [31:0]              rcv_data,
    input  logic                     tx_empty,
    input  logic [31:0]              tx_data,
    output logic                     tx_deq,
    output logic                     encrypt_pulse,
    output logic                     decrypt_pulse,
    output logic [32*KEY_WORDS-1:0]  key_out,
    output logic                     key_load
);

    localparam int unsigned IDX_W   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int unsigned CNT_W   = $clog2(STALL_MAX + 1);
    localparam int unsigned KEY_END = OFF_KEY + 4 * KEY_WORDS;

    state_e               state_q;
    reg_sel_e             sel_q;
    logic                 write_q;
    logic [IDX_W-1:0]     kidx_q;
    logic [CNT_W-1:0]     stall_cnt_q;

    logic                 accept_c;
    logic                 legal_c;
    logic                 mapped_c;
    reg_sel_e             addr_sel_c;
    logic [ADDR_W-1:0]    key_off_c;
    logic [IDX_W-1:0]     addr_kidx_c;

    logic                 busy_c;
    logic                 bp_c;
    logic                 ctrl_bad_c;
    logic                 done_c;
    logic                 timeout_c;
    logic                 key_we_c;
    logic [31:0]          key_rdata_c;
    logic [31:0]          rd_mux_c;

    // Address-phase decode and legality
    always_comb begin
        accept_c   = HSEL && HREADY && (HTRANS != HTRANS_IDLE) && (HTRANS != HTRANS_BUSY);
        key_off_c  = HADDR - ADDR_W'(OFF_KEY);
        addr_kidx_c = IDX_W'(key_off_c >> 2);
        addr_sel_c = SEL_DATA;
        mapped_c   = 1'b1;
        if (HADDR == ADDR_W'(OFF_DATA)) begin
            addr_sel_c = SEL_DATA;
        end else if (HADDR == ADDR_W'(OFF_STATUS)) begin
            addr_sel_c = SEL_STATUS;
        end else if (HADDR == ADDR_W'(OFF_CTRL)) begin
            addr_sel_c = SEL_CTRL;
        end else if ((32'(HADDR) >= OFF_KEY) && (32'(HADDR) < KEY_END)) begin
            addr_sel_c = SEL_KEY;
        end else begin
            mapped_c = 1'b0;
        end
        legal_c = mapped_c && (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00)
                  && !((addr_sel_c == SEL_STATUS) && HWRITE);
    end

    // Data-phase status: back-pressure, bad CTRL write, completion
    always_comb begin
        busy_c     = (state_q == ST_ACCESS) || (state_q == ST_STALL);
        bp_c       = busy_c && (sel_q == SEL_DATA) && (write_q ? rcv_full : tx_empty);
        ctrl_bad_c = (state_q == ST_ACCESS) && (sel_q == SEL_CTRL) && write_q
                     && (HWDATA[1:0] == 2'b11);
        done_c     = busy_c && !bp_c && !ctrl_bad_c;
        timeout_c  = (stall_cnt_q == CNT_W'(STALL_MAX - 1));
        key_we_c   = done_c && write_q && (sel_q == SEL_KEY);
    end

    // Read-data selection for the current data phase
    always_comb begin
        rd_mux_c = '0;
        case (sel_q)
            SEL_DATA:   rd_mux_c = tx_data;
            SEL_STATUS: rd_mux_c = 32'(status);
            SEL_KEY:    rd_mux_c = key_rdata_c;
            default:    rd_mux_c = '0;
        endcase
    end

    // Bus response and core strobes, all qualified by the data-phase state
    always_comb begin
        HREADYOUT     = !(bp_c || ctrl_bad_c || (state_q == ST_ERR1));
        HRESP         = ((state_q == ST_ERR1) || (state_q == ST_ERR2) || ctrl_bad_c)
                        ? HRESP_ERROR : HRESP_OKAY;
        HRDATA        = (done_c && !write_q) ? rd_mux_c : '0;
        rcv_enq       = done_c && write_q && (sel_q == SEL_DATA);
        rcv_data      = rcv_enq ? HWDATA : '0;
        tx_deq        = done_c && !write_q && (sel_q == SEL_DATA);
        encrypt_pulse = done_c && write_q && (sel_q == SEL_CTRL) && HWDATA[0];
        decrypt_pulse = done_c && write_q && (sel_q == SEL_CTRL) && HWDATA[1];
    end

    // Transfer FSM with stall counter and captured address-phase fields
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_DATA;
            write_q     <= 1'b0;
            kidx_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_ERR1: state_q <= ST_ERR2;
                default: begin
                    if (ctrl_bad_c) begin
                        state_q <= ST_ERR2;
                    end else if (bp_c) begin
                        if (timeout_c) begin
                            state_q     <= ST_ERR1;
                            stall_cnt_q <= '0;
                        end else begin
                            state_q     <= ST_STALL;
                            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        stall_cnt_q <= '0;
                        if (accept_c) begin
                            state_q <= legal_c ? ST_ACCESS : ST_ERR1;
                            sel_q   <= addr_sel_c;
                            write_q <= HWRITE;
                            kidx_q  <= addr_kidx_c;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    ahb_key_bank #(
        .KEY_WORDS (KEY_WORDS),
        .IDX_W     (IDX_W)
    ) u_key_bank (
        .clk_i      (HCLK),
        .rst_i      (HRESET),
        .we_i       (key_we_c),
        .idx_i      (kidx_q),
        .wdata_i    (HWDATA),
        .rdata_o    (key_rdata_c),
        .key_o      (key_out),
        .key_load_o (key_load)
    );

endmodule

// File: tb/tb_ahb_slave_mmio.sv
// Directed bench for ahb_slave_mmio: FIFO port, stalls, errors, keys, control, reset.
module tb_ahb_slave_mmio;
    import ahb_slave_pkg::*;

    localparam int unsigned KEY_WORDS = 4;
    localparam int unsigned STATUS_W  = 5;
    localparam int unsigned STALL_MAX = 16;
    localparam int unsigned ADDR_W    = 8;

    logic                    HCLK;
    logic                    HRESET;
    logic                    HSEL;
    logic [ADDR_W-1:0]       HADDR;
    logic [1:0]              HTRANS;
    logic [2:0]              HSIZE;
    logic                    HWRITE;
    logic [31:0]             HWDATA;
    logic                    HREADY;
    logic                    HREADYOUT;
    logic [1:0]              HRESP;
    logic [31:0]             HRDATA;
    logic [STATUS_W-1:0]     status;
    logic                    rcv_full;
    logic                    rcv_enq;
    logic [31:0]             rcv_data;
    logic                    tx_empty;
    logic [31:0]             tx_data;
    logic                    tx_deq;
    logic                    encrypt_pulse;
    logic                    decrypt_pulse;
    logic [32*KEY_WORDS-1:0] key_out;
    logic                    key_load;

    int checks = 0;
    int errors = 0;

    // Single slave on the bus: its ready is the bus ready
    assign HREADY = HREADYOUT;

    ahb_slave_mmio #(
        .KEY_WORDS (KEY_WORDS),
        .STATUS_W  (STATUS_W),
        .STALL_MAX (STALL_MAX),
        .ADDR_W    (ADDR_W)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HSEL          (HSEL),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HSIZE         (HSIZE),
        .HWRITE        (HWRITE),
        .HWDATA        (HWDATA),
        .HREADY        (HREADY),
        .HREADYOUT     (HREADYOUT),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .status        (status),
        .rcv_full      (rcv_full),
        .rcv_enq       (rcv_enq),
        .rcv_data      (rcv_data),
        .tx_empty      (tx_empty),
        .tx_data       (tx_data),
        .tx_deq        (tx_deq),
        .encrypt_pulse (encrypt_pulse),
        .decrypt_pulse (decrypt_pulse),
        .key_out       (key_out),
        .key_load      (key_load)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_key(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%032h expected=0x%032h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic rdy, input logic [1:0] resp);
        chk({tag, "_rdy"}, 32'(HREADYOUT), 32'(rdy));
        chk({tag, "_resp"}, 32'(HRESP), 32'(resp));
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic addr(input logic [7:0] a, input logic wr, input logic [2:0] sz);
        HSEL   = 1'b1;
        HADDR  = a;
        HWRITE = wr;
        HSIZE  = sz;
        HTRANS = HTRANS_NONSEQ;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HADDR  = '0;
        HWRITE = 1'b0;
        HSIZE  = HSIZE_WORD;
        HTRANS = HTRANS_IDLE;
    endtask

    initial begin
        HRESET   = 1'b1;
        bus_idle();
        HWDATA   = '0;
        status   = 5'h15;
        rcv_full = 1'b0;
        tx_empty = 1'b0;
        tx_data  = '0;

        // Reset values
        smp();
        chk_resp("rst", 1'b1, HRESP_OKAY);
        chk("rst_rdata", HRDATA, 32'h0);
        chk("rst_enq", 32'(rcv_enq), 32'h0);
        chk("rst_deq", 32'(tx_deq), 32'h0);
        chk("rst_pulses", 32'({encrypt_pulse, decrypt_pulse}), 32'h0);
        chk("rst_keyload", 32'(key_load), 32'h0);
        chk_key("rst_key", key_out, 128'h0);
        cyc();
        HRESET = 1'b0;

        // DATA write, no back-pressure
        addr(8'h00, 1'b1, HSIZE_WORD);
        cyc();
        bus_idle();
        HWDATA = 32'hDEADBEEF;
        smp();
        chk_resp("wr_data", 1'b1, HRESP_OKAY);
        chk("wr_data_enq", 32'(rcv_enq), 32'h1);
        chk("wr_data_val", rcv_data, 32'hDEADBEEF);
        cyc();
        HWDATA = '0;
        smp();
        chk("wr_data_enq_off", 32'(rcv_enq), 32'h0);

        // DATA read with three wait states
        cyc();
        addr(8'h00, 1'b0, HSIZE_WORD);
        tx_empty = 1'b1;
        cyc();
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rd_wait_rdy", 32'(HREADYOUT), 32'h0);
            chk("rd_wait_deq", 32'(tx_deq), 32'h0);
            cyc();
        end
        tx_empty = 1'b0;
        tx_data  = 32'h12345678;
        smp();
        chk_resp("rd_done", 1'b1, HRESP_OKAY);
        chk("rd_done_data", HRDATA, 32'h12345678);
        chk("rd_done_deq", 32'(tx_deq), 32'h1);
        cyc();
        smp();
        chk("rd_after_deq", 32'(tx_deq), 32'h0);
        chk("rd_after_data", HRDATA, 32'h0);

        // DATA read that never unblocks: timeout then two-cycle error
        cyc();
        addr(8'h00, 1'b0, HSIZE_WORD);
        tx_empty = 1'b1;
        cyc();
        bus_idle();
        for (int i = 0; i < 16; i++) begin
            smp();
            chk_resp("to_wait", 1'b0, HRESP_OKAY);
            chk("to_wait_deq", 32'(tx_deq), 32'h0);
            cyc();
        end
        smp();
        chk_resp("to_err1", 1'b0, HRESP_ERROR);
        chk("to_err1_deq", 32'(tx_deq), 32'h0);
        cyc();
        smp();
        chk_resp("to_err2", 1'b1, HRESP_ERROR);
        chk("to_err2_deq", 32'(tx_deq), 32'h0);
        chk("to_err2_data", HRDATA, 32'h0);
        cyc();
        tx_empty = 1'b0;
        smp();
        chk_resp("to_idle", 1'b1, HRESP_OKAY);

        // Byte write to KEY[0] is illegal
        cyc();
        addr(8'h10, 1'b1, 3'b000);
        cyc();
        bus_idle();
        HWDATA = 32'hFFFFFFFF;
        smp();
        chk_resp("byte_err1", 1'b0, HRESP_ERROR);
        cyc();
        smp();
        chk_resp("byte_err2", 1'b1, HRESP_ERROR);

        // Write to STATUS is illegal
        cyc();
        addr(8'h04, 1'b1, HSIZE_WORD);
        cyc();
        bus_idle();
        smp();
        chk_resp("stw_err1", 1'b0, HRESP_ERROR);
        cyc();
        smp();
        chk_resp("stw_err2", 1'b1, HRESP_ERROR);
        cyc();
        HWDATA = '0;
        smp();
        chk_key("err_key_kept", key_out, 128'h0);

        // STATUS read samples status during the data phase
        cyc();
        addr(8'h04, 1'b0, HSIZE_WORD);
        cyc();
        bus_idle();
        status = 5'h0A;
        smp();
        chk_resp("st_rd", 1'b1, HRESP_OKAY);
        chk("st_rd_data", HRDATA, 32'h0000000A);

        // Unmapped offset 0x0C
        cyc();
        addr(8'h0C, 1'b0, HSIZE_WORD);
        cyc();
        bus_idle();
        smp();
        chk_resp("unmap_err1", 1'b0, HRESP_ERROR);
        chk("unmap_data", HRDATA, 32'h0);
        cyc();
        smp();
        chk_resp("unmap_err2", 1'b1, HRESP_ERROR);

        // Back-to-back KEY[0..3] writes
        cyc();
        addr(8'h10, 1'b1, HSIZE_WORD);
        cyc();
        addr(8'h14, 1'b1, HSIZE_WORD);
        HWDATA = 32'h0;
        smp();
        chk("key0_rdy", 32'(HREADYOUT), 32'h1);
        cyc();
        addr(8'h18, 1'b1, HSIZE_WORD);
        HWDATA = 32'h1;
        smp();
        chk("key1_rdy", 32'(HREADYOUT), 32'h1);
        cyc();
        addr(8'h1C, 1'b1, HSIZE_WORD);
        HWDATA = 32'h2;
        smp();
        chk("key2_rdy", 32'(HREADYOUT), 32'h1);
        chk("key2_load", 32'(key_load), 32'h0);
        cyc();
        bus_idle();
        HWDATA = 32'h3;
        smp();
        chk("key3_rdy", 32'(HREADYOUT), 32'h1);
        chk("key3_load", 32'(key_load), 32'h0);
        cyc();
        HWDATA = '0;
        smp();
        chk("key_load_pulse", 32'(key_load), 32'h1);
        chk_key("key_bank", key_out, 128'h00000003_00000002_00000001_00000000);
        cyc();
        smp();
        chk("key_load_off", 32'(key_load), 32'h0);

        // KEY[2] read-back
        cyc();
        addr(8'h18, 1'b0, HSIZE_WORD);
        cyc();
        bus_idle();
        smp();
        chk("key2_rd", HRDATA, 32'h2);

        // CTRL encrypt
        cyc();
        addr(8'h08, 1'b1, HSIZE_WORD);
        cyc();
        bus_idle();
        HWDATA = 32'h1;
        smp();
        chk_resp("enc", 1'b1, HRESP_OKAY);
        chk("enc_pulse", 32'({encrypt_pulse, decrypt_pulse}), 32'h2);
        cyc();
        HWDATA = '0;
        smp();
        chk("enc_pulse_off", 32'({encrypt_pulse, decrypt_pulse}), 32'h0);

        // CTRL decrypt
        cyc();
        addr(8'h08, 1'b1, HSIZE_WORD);
        cyc();
        bus_idle();
        HWDATA = 32'h2;
        smp();
        chk("dec_pulse", 32'({encrypt_pulse, decrypt_pulse}), 32'h1);

        // CTRL with both bits is an error and fires nothing
        cyc();
        addr(8'h08, 1'b1, HSIZE_WORD);
        cyc();
        bus_idle();
        HWDATA = 32'h3;
        smp();
        chk_resp("ctrl3_err1", 1'b0, HRESP_ERROR);
        chk("ctrl3_pulse1", 32'({encrypt_pulse, decrypt_pulse}), 32'h0);
        cyc();
        HWDATA = '0;
        smp();
        chk_resp("ctrl3_err2", 1'b1, HRESP_ERROR);
        chk("ctrl3_pulse2", 32'({encrypt_pulse, decrypt_pulse}), 32'h0);
        cyc();
        smp();
        chk_resp("ctrl3_idle", 1'b1, HRESP_OKAY);

        // Selected IDLE transfer has no effect
        cyc();
        HSEL   = 1'b1;
        HADDR  = 8'h00;
        HWRITE = 1'b1;
        HTRANS = HTRANS_IDLE;
        cyc();
        bus_idle();
        HWDATA = 32'h0000AAAA;
        smp();
        chk_resp("htidle", 1'b1, HRESP_OKAY);
        chk("htidle_enq", 32'(rcv_enq), 32'h0);

        // Reset during a write stall
        cyc();
        addr(8'h00, 1'b1, HSIZE_WORD);
        rcv_full = 1'b1;
        cyc();
        bus_idle();
        HWDATA = 32'h00000055;
        smp();
        chk("rs_wait_rdy", 32'(HREADYOUT), 32'h0);
        chk("rs_wait_enq", 32'(rcv_enq), 32'h0);
        cyc();
        smp();
        chk("rs_wait2_rdy", 32'(HREADYOUT), 32'h0);
        HRESET = 1'b1;
        #1;
        chk_resp("rs_async", 1'b1, HRESP_OKAY);
        chk("rs_async_enq", 32'(rcv_enq), 32'h0);
        chk("rs_async_rdata", HRDATA, 32'h0);
        chk_key("rs_async_key", key_out, 128'h0);
        cyc();
        HRESET   = 1'b0;
        rcv_full = 1'b0;
        smp();
        chk_resp("rs_after", 1'b1, HRESP_OKAY);
        chk("rs_after_enq", 32'(rcv_enq), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
